if_inst_queue: RTL and testbench

- Decoupling FIFO between the IF stage and the ID stage of the LoongArch pipeline.
- Accepts fetched packets of {ecode, ex, inst, pc} from IF over the valid/allowin handshake.
- Presents them in order to ID over the same handshake.
- Absorbs ID stalls so IF keeps issuing instruction-SRAM requests.
- Discards all contents on branch cancel or pipeline flush (exception/ertn).

---
 rtl/if_inst_queue.sv | 74 +++++++
 tb/tb_if_inst_queue.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/if_inst_queue.sv
// Decoupling FIFO between IF and ID: holds fetched {ecode, ex, inst, pc} packets
// so IF keeps issuing while ID stalls; emptied on branch cancel or pipeline flush.
module if_inst_queue #(
  parameter int DEPTH  = 4,
  parameter int BUS_WD = 71,
  parameter int PTR_WD = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fs_to_ds_valid,
  input  logic [BUS_WD-1:0] fs_to_ds_bus,
  output logic              iq_allowin,
  output logic              iq_to_ds_valid,
  output logic [BUS_WD-1:0] iq_to_ds_bus,
  input  logic              ds_allowin,
  input  logic              br_taken_cancel,
  input  logic              flush_pipe,
  output logic [PTR_WD:0]   iq_count,
  output logic              iq_ex_block
);

  localparam logic [PTR_WD:0] FULL = (PTR_WD+1)'(DEPTH);
  localparam int EX_BIT = BUS_WD - 7;

  logic [BUS_WD-1:0] mem [DEPTH];
  logic [PTR_WD-1:0] rd_ptr;
  logic [PTR_WD-1:0] wr_ptr;
  logic [PTR_WD:0]   count;
  logic              ex_block;
  logic              push;
  logic              pop;

  // allowin looks only at registered state so ID's stall never reaches IF combinationally
  assign iq_allowin     = (count != FULL) && !ex_block && !reset;
  assign iq_to_ds_valid = (count != '0);
  assign iq_to_ds_bus   = iq_to_ds_valid ? mem[rd_ptr] : '0;
  assign iq_count       = count;
  assign iq_ex_block    = ex_block;

  assign push = fs_to_ds_valid && iq_allowin && !br_taken_cancel && !flush_pipe;
  assign pop  = iq_to_ds_valid && ds_allowin && !flush_pipe;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= fs_to_ds_bus;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      ex_block <= 1'b0;
    end else if (flush_pipe) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      ex_block <= 1'b0;
    end else if (br_taken_cancel) begin
      // the head may still be consumed this cycle, everything younger is discarded
      rd_ptr   <= wr_ptr;
      count    <= '0;
      ex_block <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (fs_to_ds_bus[EX_BIT]) ex_block <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_if_inst_queue.sv
// Bench for if_inst_queue: stimulus process runs a queue-level reference model and
// pushes expected head packets; a negedge monitor pops and compares on every DUT pop.
module tb_if_inst_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fs_to_ds_valid = 1'b0;
  logic [70:0] fs_to_ds_bus = '0;
  logic        iq_allowin;
  logic        iq_to_ds_valid;
  logic [70:0] iq_to_ds_bus;
  logic        ds_allowin = 1'b0;
  logic        br_taken_cancel = 1'b0;
  logic        flush_pipe = 1'b0;
  logic [2:0]  iq_count;
  logic        iq_ex_block;

  if_inst_queue #(.DEPTH(DEPTH), .BUS_WD(71), .PTR_WD(2)) dut (
    .clk(clk), .reset(reset),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .iq_allowin(iq_allowin), .iq_to_ds_valid(iq_to_ds_valid), .iq_to_ds_bus(iq_to_ds_bus),
    .ds_allowin(ds_allowin), .br_taken_cancel(br_taken_cancel), .flush_pipe(flush_pipe),
    .iq_count(iq_count), .iq_ex_block(iq_ex_block)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [70:0] m_q[$];
  logic [70:0] exp_q[$];
  logic        m_ex = 1'b0;
  logic        chk_en = 1'b0;
  logic        m_rst, m_allow, m_valid, m_exb;
  int          m_count;

  task automatic chk(input string name, input logic [70:0] act, input logic [70:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [70:0] mk(input logic [31:0] pc, input logic ex, input logic [5:0] ec);
    logic [31:0] inst;
    inst = $urandom;
    return {ec, ex, inst, pc};
  endfunction

  // one clock cycle: drive inputs just after the edge, then advance the model
  task automatic cyc(input logic v, input logic [70:0] b, input logic da,
                     input logic bc, input logic fl, input logic rs);
    logic do_push, do_pop;
    @(posedge clk);
    #1;
    fs_to_ds_valid  = v;
    fs_to_ds_bus    = b;
    ds_allowin      = da;
    br_taken_cancel = bc;
    flush_pipe      = fl;
    reset           = rs;
    m_rst   = rs;
    m_count = m_q.size();
    m_valid = (m_q.size() != 0);
    m_exb   = m_ex;
    m_allow = (m_q.size() < DEPTH) && !m_ex && !rs;
    do_pop  = !rs && m_valid && da && !fl;
    do_push = v && m_allow && !bc && !fl;
    if (do_pop) exp_q.push_back(m_q.pop_front());
    if (rs || fl || bc) begin
      m_q.delete();
      m_ex = 1'b0;
    end else if (do_push) begin
      m_q.push_back(b);
      if (b[64]) m_ex = 1'b1;
    end
  endtask

  task automatic idle(input logic da);
    cyc(1'b0, '0, da, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic put(input logic [31:0] pc, input logic da);
    cyc(1'b1, mk(pc, 1'b0, 6'h0), da, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("allowin", 71'(iq_allowin), 71'(m_allow));
      if (!m_rst) begin
        chk("count", 71'(iq_count), 71'(m_count));
        chk("valid", 71'(iq_to_ds_valid), 71'(m_valid));
        chk("ex_block", 71'(iq_ex_block), 71'(m_exb));
        if (iq_to_ds_valid && ds_allowin && !flush_pipe) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pop_unexpected: got pop of %h want no pop at %0t", iq_to_ds_bus, $time);
          end else begin
            chk("head_bus", iq_to_ds_bus, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    chk_en = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    chk("reset_bus", iq_to_ds_bus, '0);

    // fill then drain
    for (int i = 0; i < 4; i++) put(32'h1c000000 + 32'(4 * i), 1'b0);
    idle(1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // streaming across pointer wrap
    for (int i = 0; i < 10; i++) put(32'h1c000040 + 32'(4 * i), 1'b1);
    idle(1'b1);
    idle(1'b1);

    // branch cancel with concurrent push
    put(32'h1c000010, 1'b0);
    put(32'h1c000014, 1'b0);
    put(32'h1c000018, 1'b0);
    cyc(1'b1, mk(32'h1c00001c, 1'b0, 6'h0), 1'b1, 1'b1, 1'b0, 1'b0);
    put(32'h1c000100, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // fetch exception blocks intake until flush
    cyc(1'b1, mk(32'h1c000002, 1'b1, 6'h08), 1'b0, 1'b0, 1'b0, 1'b0);
    put(32'h1c000006, 1'b1);
    put(32'h1c00000a, 1'b1);
    put(32'h1c00000e, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b0);

    // flush with concurrent push and pop
    put(32'h1c000200, 1'b0);
    put(32'h1c000204, 1'b0);
    cyc(1'b1, mk(32'h1c000208, 1'b0, 6'h0), 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1'b1);

    // reset mid-operation
    for (int i = 0; i < 3; i++) put(32'h1c000300 + 32'(4 * i), 1'b0);
    cyc(1'b1, mk(32'h1c00030c, 1'b0, 6'h0), 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1'b0);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic v, da, bc, fl, rs, ex;
      v  = ($urandom_range(3) != 0);
      da = $urandom_range(1);
      bc = ($urandom_range(15) == 0);
      fl = ($urandom_range(31) == 0);
      rs = ($urandom_range(99) == 0);
      ex = ($urandom_range(15) == 0);
      cyc(v, mk(32'h1c000000 + 32'($urandom_range(4095) * 4), ex, ex ? 6'h08 : 6'h00),
          da, bc, fl, rs);
    end

    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
    @(negedge clk);
    #1;
    chk("leftover_expected", 71'(exp_q.size()), 71'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
